mips_mem_responder: RTL and testbench
=====================================

Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS control unit: services its InsRead, MemRead and MemWrite strobes against one single-port word RAM.
- Returns the fetched instruction, the load data, or a write acknowledgement after a configurable number of wait states.
- Holds results stable for the datapath, and buffers one request that arrives while busy.

Parameters:
- BUS_WIDTH, 16, data/instruction/address word width
- ADDR_WIDTH, 8, RAM word-address bits (depth 2^ADDR_WIDTH)
- WAIT_CYCLES, 1, extra access cycles per request (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- InsRead  in  1  instruction fetch request strobe
- MemRead  in  1  data load request strobe
- MemWrite  in  1  data store request strobe
- PCAddr  in  BUS_WIDTH  fetch word address
- DataAddr  in  BUS_WIDTH  load/store word address (ALU result)
- WrData  in  BUS_WIDTH  store data
- InsOut  out  BUS_WIDTH  last fetched instruction, held
- RdData  out  BUS_WIDTH  last loaded data, held
- InsValid  out  1  one-cycle pulse: InsOut updated
- RdValid  out  1  one-cycle pulse: RdData updated
- WrDone  out  1  one-cycle pulse: store committed
- Busy  out  1  high whenever state is not IDLE or pending is occupied
- Overflow  out  1  sticky: a request was dropped

Behaviour:
- Reset (rst_n low at an edge) takes priority over everything:
  - state becomes IDLE; pending is cleared; wait counter is cleared.
  - InsOut=0, RdData=0, InsValid=0, RdValid=0, WrDone=0, Busy=0, Overflow=0.
  - RAM contents are not cleared.
- Strobes are sampled every edge and are level-true only for that cycle. No handshake back-pressure is applied to the requester.
- Priority on simultaneous strobes: MemWrite > MemRead > InsRead.
- Address use: RAM index is the address bits [ADDR_WIDTH-1:0]. Upper bits are ignored, so addresses wrap.
- At sampling, the module captures the request type, the address (PCAddr for fetch, DataAddr for load/store) and WrData.
- FSM states are IDLE, ACCESS, RESP.
  - IDLE: if any strobe is high, capture the highest-priority request, load counter=WAIT_CYCLES, and go to ACCESS. If a second strobe is also high, it goes to pending. A third strobe is dropped and sets Overflow.
  - ACCESS: while counter != 0, decrement. When counter == 0:
    - perform the RAM operation (write commits at this edge; read data is registered at this edge);
    - go to RESP.
  - RESP, for exactly one cycle, and on the edge leaving RESP:
    - assert the matching pulse: InsValid with InsOut loaded, RdValid with RdData loaded, or WrDone.
    - If pending is valid: pending moves to active, counter reloads, go to ACCESS.
    - Otherwise go to IDLE.
- Latency: the pulse is high in the cycle beginning WAIT_CYCLES+2 edges after the sampling edge. With WAIT_CYCLES=1 this is 3 edges.
- Pending buffer (one entry):
  - Strobes seen in ACCESS or RESP are written to pending, highest priority first.
  - If pending is already occupied, or a strobe cannot fit, that request is dropped and Overflow sets (sticky until reset).
- InsOut and RdData change only on their own response. A store never alters RdData.
- Read-after-write to the same address, back to back, returns the newly written data.
- Reset mid-ACCESS: no write occurs unless its commit edge has already passed; the in-flight response is discarded.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding: ST_IDLE, ST_ACCESS, ST_RESP;
  - request type codes: REQ_NONE, REQ_INS, REQ_RD, REQ_WR;
  - request record of type, address and data.
- One sub-module, mips_sp_ram: a single-port synchronous RAM.
  - Ports: clk, en, we, addr[ADDR_WIDTH], wdata, rdata (registered).
  - No reset on the array.

Test Plan:
1. Reset then fetch: preload RAM[0x03]=0x4A21; pulse InsRead with PCAddr=0x0003 -> InsValid high for exactly one cycle, 3 edges after sampling; InsOut=0x4A21 and held afterwards; Busy low one edge later.
2. Store then load: MemWrite DataAddr=0x0010 WrData=0xBEEF -> WrDone pulse; then MemRead DataAddr=0x0110 (aliases to 0x10) -> RdValid with RdData=0xBEEF; InsOut unchanged.
3. Simultaneous strobes in IDLE: MemWrite(0x20, 0x1234) + MemRead(0x20) -> WrDone first; the read is served from pending; RdValid 3 edges later with RdData=0x1234; Overflow stays 0.
4. Overflow: InsRead+MemRead+MemWrite together -> store, then load, serviced; fetch dropped; Overflow=1 and remains 1 until rst_n low.
5. Reset mid-operation: MemWrite(0x05, 0xAAAA) then rst_n low on the next edge (before commit) -> all outputs 0; a subsequent MemRead(0x05) returns the preloaded value, not 0xAAAA.
6. WAIT_CYCLES=0 build: InsRead at PCAddr=0x01 -> InsValid 2 edges after sampling; back-to-back fetches every 2 cycles with no Overflow.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory responder: FSM states, request kinds and the
// request record held in the active and pending slots.
package mips_mem_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  typedef enum logic [1:0] {REQ_NONE, REQ_INS, REQ_RD, REQ_WR} req_kind_e;

  // Record fields are sized for the widest supported bus; narrower builds zero-extend.
  localparam int REQ_WIDTH = 32;

  typedef struct packed {
    req_kind_e            kind;
    logic [REQ_WIDTH-1:0] addr;
    logic [REQ_WIDTH-1:0] data;
  } req_t;

  function automatic req_t make_req(req_kind_e kind, logic [REQ_WIDTH-1:0] addr,
                                    logic [REQ_WIDTH-1:0] data);
    req_t r;
    r.kind = kind;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/mips_sp_ram.sv
// Single-port synchronous word RAM with registered read data; the array is never reset.
module mips_sp_ram #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  output logic [BUS_WIDTH-1:0]  rdata
);

  logic [BUS_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [BUS_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS control unit: one active request,
// one pending slot, WAIT_CYCLES extra access cycles, held results and one-cycle pulses.
module mips_mem_responder #(
  parameter int BUS_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 InsRead,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [BUS_WIDTH-1:0] PCAddr,
  input  logic [BUS_WIDTH-1:0] DataAddr,
  input  logic [BUS_WIDTH-1:0] WrData,
  output logic [BUS_WIDTH-1:0] InsOut,
  output logic [BUS_WIDTH-1:0] RdData,
  output logic                 InsValid,
  output logic                 RdValid,
  output logic                 WrDone,
  output logic                 Busy,
  output logic                 Overflow
);
  import mips_mem_pkg::*;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  req_t                 act_q, act_d, pend_q, pend_d;
  logic [BUS_WIDTH-1:0] ins_out_q, ins_out_d, rd_data_q, rd_data_d;
  logic                 ins_valid_q, ins_valid_d, rd_valid_q, rd_valid_d;
  logic                 wr_done_q, wr_done_d, overflow_q, overflow_d;

  req_t                 wr_req, rd_req, ins_req, in0, in1;
  logic [1:0]           n_in;
  logic                 admit;
  logic                 ram_en, ram_we;
  logic [BUS_WIDTH-1:0] ram_rdata;
  logic                 unused_hi;

  assign wr_req  = make_req(REQ_WR,  REQ_WIDTH'(DataAddr), REQ_WIDTH'(WrData));
  assign rd_req  = make_req(REQ_RD,  REQ_WIDTH'(DataAddr), REQ_WIDTH'(WrData));
  assign ins_req = make_req(REQ_INS, REQ_WIDTH'(PCAddr),   REQ_WIDTH'(WrData));

  // Sort this cycle's strobes into priority order: in0 highest, in1 next.
  always_comb begin
    in0  = '0;
    in1  = '0;
    n_in = 2'd0;
    if (MemWrite) begin
      in0  = wr_req;
      n_in = 2'd1;
    end
    if (MemRead) begin
      if (n_in == 2'd0) in0 = rd_req;
      else              in1 = rd_req;
      n_in = n_in + 2'd1;
    end
    if (InsRead) begin
      if (n_in == 2'd0)      in0 = ins_req;
      else if (n_in == 2'd1) in1 = ins_req;
      n_in = n_in + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      ins_out_q   <= '0;
      rd_data_q   <= '0;
      ins_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      ins_out_q   <= ins_out_d;
      rd_data_q   <= rd_data_d;
      ins_valid_q <= ins_valid_d;
      rd_valid_q  <= rd_valid_d;
      wr_done_q   <= wr_done_d;
      overflow_q  <= overflow_d;
    end
  end

  // A RESP with nothing pending frees the active slot, so it admits strobes like IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    pend_d     = pend_q;
    overflow_d = overflow_q;
    admit      = 1'b0;
    case (state_q)
      ST_IDLE:   admit = 1'b1;
      ST_ACCESS: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = ST_RESP;
      end
      ST_RESP: begin
        if (pend_q.kind != REQ_NONE) begin
          act_d   = pend_q;
          pend_d  = '0;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_ACCESS;
        end else begin
          admit   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    if (admit) begin
      if (n_in != 2'd0) begin
        act_d   = in0;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = ST_ACCESS;
      end
      if (n_in >= 2'd2) pend_d = in1;
      if (n_in == 2'd3) overflow_d = 1'b1;
    end else if (n_in != 2'd0) begin
      if (pend_d.kind == REQ_NONE) pend_d = in0;
      else                         overflow_d = 1'b1;
      if (n_in >= 2'd2) overflow_d = 1'b1;
    end
  end

  // RAM is touched only on the last ACCESS cycle; reset at that edge suppresses the write.
  always_comb begin
    ram_en      = rst_n && (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    ram_we      = ram_en && (act_q.kind == REQ_WR);
    ins_valid_d = 1'b0;
    rd_valid_d  = 1'b0;
    wr_done_d   = 1'b0;
    ins_out_d   = ins_out_q;
    rd_data_d   = rd_data_q;
    if (state_q == ST_RESP) begin
      case (act_q.kind)
        REQ_INS: begin
          ins_valid_d = 1'b1;
          ins_out_d   = ram_rdata;
        end
        REQ_RD: begin
          rd_valid_d = 1'b1;
          rd_data_d  = ram_rdata;
        end
        REQ_WR:  wr_done_d = 1'b1;
        default: ;
      endcase
    end
  end

  mips_sp_ram #(
    .BUS_WIDTH (BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (act_q.addr[ADDR_WIDTH-1:0]),
    .wdata(act_q.data[BUS_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

  assign unused_hi = ^{act_q.addr, act_q.data};

  assign InsOut   = ins_out_q;
  assign RdData   = rd_data_q;
  assign InsValid = ins_valid_q;
  assign RdValid  = rd_valid_q;
  assign WrDone   = wr_done_q;
  assign Overflow = overflow_q;
  assign Busy     = (state_q != ST_IDLE) || (pend_q.kind != REQ_NONE);

endmodule

// File: tb/tb_mips_mem_responder.sv
// Drives a WAIT_CYCLES=0 and a WAIT_CYCLES=1 responder with the same stimulus and compares
// both every cycle against a request-scheduling model with a word-array memory.
module tb_mips_mem_responder;

  localparam int W0 = 0;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ins_rd = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [15:0] pc_addr = '0, data_addr = '0, wr_data = '0;

  logic [1:0][15:0] ins_out, rd_data;
  logic [1:0]       ins_valid, rd_valid, wr_done, busy, overflow;

  // Model: kind 0 none, 1 fetch, 2 load, 3 store; done_at is the edge the pulse appears.
  logic [15:0] m_mem [2][256];
  int          m_act_kind [2], m_act_done [2], m_pend_kind [2];
  logic [15:0] m_act_addr [2], m_act_data [2], m_pend_addr [2], m_pend_data [2];
  logic [15:0] e_ins_out [2], e_rd_data [2];
  logic        e_ins_valid [2], e_rd_valid [2], e_wr_done [2], e_overflow [2];
  int          edge_no = 0;
  int          n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(.BUS_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .InsRead(ins_rd), .MemRead(mem_rd), .MemWrite(mem_wr),
    .PCAddr(pc_addr), .DataAddr(data_addr), .WrData(wr_data),
    .InsOut(ins_out[0]), .RdData(rd_data[0]), .InsValid(ins_valid[0]), .RdValid(rd_valid[0]),
    .WrDone(wr_done[0]), .Busy(busy[0]), .Overflow(overflow[0])
  );

  mips_mem_responder #(.BUS_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .InsRead(ins_rd), .MemRead(mem_rd), .MemWrite(mem_wr),
    .PCAddr(pc_addr), .DataAddr(data_addr), .WrData(wr_data),
    .InsOut(ins_out[1]), .RdData(rd_data[1]), .InsValid(ins_valid[1]), .RdValid(rd_valid[1]),
    .WrDone(wr_done[1]), .Busy(busy[1]), .Overflow(overflow[1])
  );

  function automatic int waitOf(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s got=%h expected=%h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic offerReq(input int k, input int kind, input logic [15:0] addr,
                          input logic [15:0] data);
    if (m_act_kind[k] == 0) begin
      m_act_kind[k] = kind;
      m_act_addr[k] = addr;
      m_act_data[k] = data;
      m_act_done[k] = edge_no + waitOf(k) + 2;
    end else if (m_pend_kind[k] == 0) begin
      m_pend_kind[k] = kind;
      m_pend_addr[k] = addr;
      m_pend_data[k] = data;
    end else begin
      e_overflow[k] = 1'b1;
    end
  endtask

  task automatic modelEdge(input int k);
    e_ins_valid[k] = 1'b0;
    e_rd_valid[k]  = 1'b0;
    e_wr_done[k]   = 1'b0;
    if (!rst_n) begin
      // a store whose commit edge (one before its pulse) already passed has landed
      if (m_act_kind[k] == 3 && m_act_done[k] - 1 < edge_no)
        m_mem[k][m_act_addr[k][7:0]] = m_act_data[k];
      m_act_kind[k]  = 0;
      m_pend_kind[k] = 0;
      e_ins_out[k]   = '0;
      e_rd_data[k]   = '0;
      e_overflow[k]  = 1'b0;
      return;
    end
    if (m_act_kind[k] != 0 && m_act_done[k] == edge_no) begin
      case (m_act_kind[k])
        1: begin e_ins_valid[k] = 1'b1; e_ins_out[k] = m_mem[k][m_act_addr[k][7:0]]; end
        2: begin e_rd_valid[k] = 1'b1; e_rd_data[k] = m_mem[k][m_act_addr[k][7:0]]; end
        default: begin e_wr_done[k] = 1'b1; m_mem[k][m_act_addr[k][7:0]] = m_act_data[k]; end
      endcase
      m_act_kind[k] = 0;
      if (m_pend_kind[k] != 0) begin
        m_act_kind[k]  = m_pend_kind[k];
        m_act_addr[k]  = m_pend_addr[k];
        m_act_data[k]  = m_pend_data[k];
        m_act_done[k]  = edge_no + waitOf(k) + 2;
        m_pend_kind[k] = 0;
      end
    end
    if (mem_wr) offerReq(k, 3, data_addr, wr_data);
    if (mem_rd) offerReq(k, 2, data_addr, wr_data);
    if (ins_rd) offerReq(k, 1, pc_addr, wr_data);
  endtask

  task automatic applyStimulus(input logic rst_v, input logic ins_v, input logic rd_v,
                               input logic wr_v, input logic [15:0] pc_v,
                               input logic [15:0] da_v, input logic [15:0] wd_v);
    rst_n     = rst_v;
    ins_rd    = ins_v;
    mem_rd    = rd_v;
    mem_wr    = wr_v;
    pc_addr   = pc_v;
    data_addr = da_v;
    wr_data   = wd_v;
    @(posedge clk);
    edge_no++;
    modelEdge(0);
    modelEdge(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("w%0d_InsOut", k), ins_out[k], e_ins_out[k]);
      checkOutput($sformatf("w%0d_RdData", k), rd_data[k], e_rd_data[k]);
      checkOutput($sformatf("w%0d_InsValid", k), 16'(ins_valid[k]), 16'(e_ins_valid[k]));
      checkOutput($sformatf("w%0d_RdValid", k), 16'(rd_valid[k]), 16'(e_rd_valid[k]));
      checkOutput($sformatf("w%0d_WrDone", k), 16'(wr_done[k]), 16'(e_wr_done[k]));
      checkOutput($sformatf("w%0d_Overflow", k), 16'(overflow[k]), 16'(e_overflow[k]));
      checkOutput($sformatf("w%0d_Busy", k), 16'(busy[k]),
                  16'((m_act_kind[k] != 0) || (m_pend_kind[k] != 0)));
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act_kind[k] = 0; m_pend_kind[k] = 0; m_act_done[k] = 0;
      e_ins_out[k] = '0; e_rd_data[k] = '0; e_overflow[k] = 1'b0;
      e_ins_valid[k] = 1'b0; e_rd_valid[k] = 1'b0; e_wr_done[k] = 1'b0;
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // fill every word so all later reads have a known value
    for (int a = 0; a < 256; a++) begin
      logic [15:0] d;
      d = (a == 3) ? 16'h4A21 : (a == 5) ? 16'h5555 : 16'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, 16'(a), d);
      idleCycles(2);
    end
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("rst_insout", ins_out[1], 16'h0000);
    checkOutput("rst_busy", 16'(busy[1]), 16'h0000);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, '0, '0);
    idleCycles(2);
    checkOutput("fetch_w0_valid", 16'(ins_valid[0]), 16'h0001);
    checkOutput("fetch_w0_insout", ins_out[0], 16'h4A21);
    idleCycles(1);
    checkOutput("fetch_w1_valid", 16'(ins_valid[1]), 16'h0001);
    checkOutput("fetch_w1_insout", ins_out[1], 16'h4A21);
    checkOutput("fetch_w0_pulse_end", 16'(ins_valid[0]), 16'h0000);
    idleCycles(1);
    checkOutput("fetch_w1_pulse_end", 16'(ins_valid[1]), 16'h0000);
    checkOutput("fetch_w1_busy_low", 16'(busy[1]), 16'h0000);
    checkOutput("fetch_w1_held", ins_out[1], 16'h4A21);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, 16'h0010, 16'hBEEF);
    idleCycles(3);
    checkOutput("store_w1_done", 16'(wr_done[1]), 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 16'h0110, '0);
    idleCycles(3);
    checkOutput("alias_w1_valid", 16'(rd_valid[1]), 16'h0001);
    checkOutput("alias_w1_rddata", rd_data[1], 16'hBEEF);
    checkOutput("alias_w0_rddata", rd_data[0], 16'hBEEF);
    checkOutput("alias_w1_insout", ins_out[1], 16'h4A21);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0, 16'h0020, 16'h1234);
    idleCycles(3);
    checkOutput("dual_w1_wrdone", 16'(wr_done[1]), 16'h0001);
    idleCycles(3);
    checkOutput("dual_w1_rdvalid", 16'(rd_valid[1]), 16'h0001);
    checkOutput("dual_w1_rddata", rd_data[1], 16'h1234);
    checkOutput("dual_w1_ovf", 16'(overflow[1]), 16'h0000);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0030, 16'h7777);
    idleCycles(6);
    checkOutput("triple_w1_rddata", rd_data[1], 16'h7777);
    checkOutput("triple_w0_rddata", rd_data[0], 16'h7777);
    checkOutput("triple_w1_insout", ins_out[1], 16'h4A21);
    idleCycles(5);
    checkOutput("triple_w1_ovf_sticky", 16'(overflow[1]), 16'h0001);
    checkOutput("triple_w0_ovf_sticky", 16'(overflow[0]), 16'h0001);

    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("reset_ovf_clear", 16'(overflow[1]), 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, 16'h0005, 16'hAAAA);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("midrst_busy", 16'(busy[1]), 16'h0000);
    checkOutput("midrst_wrdone", 16'(wr_done[1]), 16'h0000);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 16'h0005, '0);
    idleCycles(3);
    checkOutput("midrst_w1_rddata", rd_data[1], 16'h5555);
    checkOutput("midrst_w0_rddata", rd_data[0], 16'h5555);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, '0, '0);
    idleCycles(1);
    checkOutput("w0_fetch_not_early", 16'(ins_valid[0]), 16'h0000);
    idleCycles(1);
    checkOutput("w0_fetch_valid", 16'(ins_valid[0]), 16'h0001);
    checkOutput("w0_fetch_insout", ins_out[0], m_mem[0][1]);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'(i * 37 + 2), '0, '0);
      idleCycles(1);
    end
    idleCycles(6);
    checkOutput("w0_b2b_no_ovf", 16'(overflow[0]), 16'h0000);

    for (int i = 0; i < 600; i++) begin
      logic r;
      r = ($urandom_range(0, 49) != 0);
      applyStimulus(r, r && ($urandom_range(0, 3) == 0), r && ($urandom_range(0, 3) == 0),
                    r && ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom),
                    16'($urandom));
    end
    idleCycles(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
